// File: rtl/mppt_po_tracker.sv
// Perturb-and-observe maximum power point tracker.
// Averages v*i over a window of 2^AVG_LOG2 valid samples. After each window it
// compares the average against the previous window and nudges the duty cycle
// one STEP in the direction that last improved power. Duty saturates at
// DUTY_MIN/DUTY_MAX, and the direction is forced back inward at either bound.
module mppt_po_tracker #(
  parameter int W         = 8,
  parameter int DUTY_W    = 8,
  parameter int AVG_LOG2  = 2,
  parameter int STEP      = 1,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int DUTY_INIT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      v_in,
  input  logic [W-1:0]      i_in,
  input  logic              s_valid,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic [2*W-1:0]    p_avg,
  output logic              dir,
  output logic [1:0]        state
);

  localparam int ACC_W = 2*W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0]   MAX_X    = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   DN_LIMIT = (DUTY_W+1)'(DUTY_MIN + STEP);
  localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_D   = DUTY_W'(DUTY_INIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t            cur_state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [2*W-1:0]    p_prev;
  logic              first_win;

  logic [2*W-1:0]    prod;
  logic [2*W-1:0]    avg_new;
  logic [DUTY_W:0]   duty_up;
  logic [DUTY_W:0]   duty_dn;
  logic [DUTY_W-1:0] duty_next;

  assign state = cur_state;

  // Power product, window average, and the saturated next duty for the current direction.
  // The +/- STEP arithmetic is one bit wider so it cannot wrap before being clamped.
  always_comb begin
    prod    = (2*W)'(v_in) * (2*W)'(i_in);
    avg_new = acc[ACC_W-1:AVG_LOG2];
    duty_up = {1'b0, duty} + STEP_X;
    duty_dn = {1'b0, duty} - STEP_X;
    if (dir) begin
      duty_next = (duty_up > MAX_X) ? MAX_D : duty_up[DUTY_W-1:0];
    end else begin
      duty_next = ({1'b0, duty} < DN_LIMIT) ? MIN_D : duty_dn[DUTY_W-1:0];
    end
  end

  // Tracker FSM: accumulate a window, decide the direction, then step the duty.
  // Dropping en from any state discards the partial window but keeps the tracking history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      duty      <= INIT_D;
      dir       <= 1'b1;
      p_avg     <= '0;
      p_prev    <= '0;
      first_win <= 1'b1;
      duty_upd  <= 1'b0;
    end else begin
      duty_upd <= 1'b0;
      if (!en) begin
        cur_state <= IDLE;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        case (cur_state)
          IDLE: begin
            acc       <= '0;
            cnt       <= '0;
            cur_state <= ACCUM;
          end
          ACCUM: begin
            if (s_valid) begin
              acc <= acc + ACC_W'(prod);
              cnt <= cnt + CNT_W'(1);
              if (cnt == CNT_LAST) begin
                cur_state <= DECIDE;
              end
            end
          end
          DECIDE: begin
            p_avg <= avg_new;
            if (!first_win && (avg_new < p_prev)) begin
              dir <= ~dir;
            end
            cur_state <= UPDATE;
          end
          UPDATE: begin
            duty      <= duty_next;
            duty_upd  <= 1'b1;
            p_prev    <= p_avg;
            first_win <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            if (duty_next == MAX_D) begin
              dir <= 1'b0;
            end else if (duty_next == MIN_D) begin
              dir <= 1'b1;
            end
            cur_state <= ACCUM;
          end
          default: begin
            cur_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_po_tracker.sv
// Self-checking bench for mppt_po_tracker.
// Two instances share the stimulus: one with default parameters and one that
// starts at the upper duty bound. A window-level reference model predicts
// p_avg, dir and duty from the raw sample values of each completed window.
module tb_mppt_po_tracker;

  localparam int W  = 8;
  localparam int DW = 8;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          s_valid;
  logic [W-1:0]  v_in;
  logic [W-1:0]  i_in;

  logic [DW-1:0]  duty_a, duty_b;
  logic           upd_a, upd_b;
  logic [2*W-1:0] pavg_a, pavg_b;
  logic           dir_a, dir_b;
  logic [1:0]     state_a, state_b;

  int errors = 0;
  int checks = 0;

  int m_duty[2];
  int m_dir[2];
  int m_pavg[2];
  int m_pprev[2];
  bit m_first[2];
  int old_duty[2];

  int va[NS];
  int ia[NS];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  mppt_po_tracker dut_a (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in), .i_in(i_in), .s_valid(s_valid),
    .duty(duty_a), .duty_upd(upd_a), .p_avg(pavg_a), .dir(dir_a), .state(state_a)
  );

  mppt_po_tracker #(.DUTY_INIT(240)) dut_b (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in), .i_in(i_in), .s_valid(s_valid),
    .duty(duty_b), .duty_upd(upd_b), .p_avg(pavg_b), .dir(dir_b), .state(state_b)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_duty[0] = 128;
    m_duty[1] = 240;
    for (int k = 0; k < 2; k++) begin
      m_dir[k]   = 1;
      m_pavg[k]  = 0;
      m_pprev[k] = 0;
      m_first[k] = 1'b1;
    end
  endtask

  task automatic modelWindow(input int sum);
    int avg;
    int nd;
    avg = sum / NS;
    for (int k = 0; k < 2; k++) begin
      if (!m_first[k] && avg < m_pprev[k]) m_dir[k] = 1 - m_dir[k];
      m_pavg[k] = avg;
      nd = (m_dir[k] == 1) ? m_duty[k] + 1 : m_duty[k] - 1;
      if (nd > 240) nd = 240;
      if (nd < 16) nd = 16;
      if (nd == 240) m_dir[k] = 0;
      else if (nd == 16) m_dir[k] = 1;
      m_duty[k]  = nd;
      m_pprev[k] = avg;
      m_first[k] = 1'b0;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_duty_a"}, duty_a, 128);
    checkOutput({tag, "_duty_b"}, duty_b, 240);
    checkOutput({tag, "_dir_a"}, dir_a, 1);
    checkOutput({tag, "_dir_b"}, dir_b, 1);
    checkOutput({tag, "_pavg_a"}, pavg_a, 0);
    checkOutput({tag, "_upd_a"}, upd_a, 0);
    checkOutput({tag, "_upd_b"}, upd_b, 0);
    checkOutput({tag, "_state_a"}, state_a, 0);
    checkOutput({tag, "_state_b"}, state_b, 0);
  endtask

  task automatic checkInst(input string tag);
    checkOutput({tag, "_duty_a"}, duty_a, m_duty[0]);
    checkOutput({tag, "_dir_a"}, dir_a, m_dir[0]);
    checkOutput({tag, "_pavg_a"}, pavg_a, m_pavg[0]);
    checkOutput({tag, "_duty_b"}, duty_b, m_duty[1]);
    checkOutput({tag, "_dir_b"}, dir_b, m_dir[1]);
    checkOutput({tag, "_pavg_b"}, pavg_b, m_pavg[1]);
  endtask

  task automatic enterAccum();
    en      = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("enter_state", state_a, 1);
  endtask

  // Feeds one full window (optionally gapped, with junk during DECIDE/UPDATE) and
  // checks every cycle of the decision pipeline. Starts and ends at a negedge in ACCUM.
  task automatic applyStimulus(input int vv[NS], input int ii[NS], input int gmin,
                               input int gmax, input bit noise, input bit rst_in_update);
    int sum;
    int gaps;
    sum = 0;
    for (int k = 0; k < NS; k++) begin
      gaps = int'($urandom_range(gmax, gmin));
      repeat (gaps) begin
        s_valid = 1'b0;
        v_in    = W'($urandom);
        i_in    = W'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      v_in    = W'(vv[k]);
      i_in    = W'(ii[k]);
      sum    += vv[k] * ii[k];
      @(negedge clk);
    end
    old_duty = m_duty;
    modelWindow(sum);
    s_valid = noise;
    v_in    = W'($urandom);
    i_in    = W'($urandom);
    checkOutput("decide_state", state_a, 2);
    checkOutput("decide_upd", upd_a, 0);
    @(negedge clk);
    checkOutput("update_state", state_b, 3);
    checkOutput("update_pavg_a", pavg_a, m_pavg[0]);
    checkOutput("update_pavg_b", pavg_b, m_pavg[1]);
    checkOutput("update_duty_held", duty_a, old_duty[0]);
    checkOutput("update_upd", upd_a, 0);
    if (rst_in_update) begin
      rst = 1'b1;
      #1;
      modelReset();
      checkReset("rst_upd");
      @(negedge clk);
      checkOutput("rst_upd_nopulse", upd_a, 0);
      checkOutput("rst_upd_duty", duty_a, 128);
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    checkInst("win");
    checkOutput("win_upd_a", upd_a, 1);
    checkOutput("win_upd_b", upd_b, 1);
    checkOutput("win_state", state_a, 1);
    @(negedge clk);
    checkOutput("win_upd_drop", upd_a, 0);
    checkOutput("win_state_hold", state_a, 1);
  endtask

  // Feeds a partial window, drops en, and verifies nothing tracked moves.
  task automatic abortWindow(input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      s_valid = 1'b1;
      v_in    = W'($urandom);
      i_in    = W'($urandom);
      @(negedge clk);
    end
    en      = 1'b0;
    s_valid = 1'($urandom);
    @(negedge clk);
    checkOutput("abort_state_a", state_a, 0);
    checkOutput("abort_state_b", state_b, 0);
    for (int c = 0; c < 2; c++) begin
      s_valid = 1'($urandom);
      v_in    = W'($urandom);
      i_in    = W'($urandom);
      @(negedge clk);
      checkOutput("abort_upd", upd_a, 0);
    end
    checkInst("abort");
    enterAccum();
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    s_valid = 1'b0;
    v_in    = '0;
    i_in    = '0;
    #1;
    modelReset();
    checkReset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    enterAccum();

    // Directed tracking sequence: 100, 120, 110, 110.
    va = '{10, 10, 10, 10};
    ia = '{10, 10, 10, 10};
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);
    checkOutput("first_pavg", pavg_a, 100);
    checkOutput("first_duty", duty_a, 129);
    checkOutput("first_dir", dir_a, 1);
    checkOutput("sat_first_duty", duty_b, 240);
    checkOutput("sat_first_dir", dir_b, 0);
    ia = '{12, 12, 12, 12};
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);
    checkOutput("rise_duty", duty_a, 130);
    checkOutput("sat_next_duty", duty_b, 239);
    ia = '{11, 11, 11, 11};
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);
    checkOutput("fall_pavg", pavg_a, 110);
    checkOutput("fall_dir", dir_a, 0);
    checkOutput("fall_duty", duty_a, 129);
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);
    checkOutput("equal_dir", dir_a, 0);
    checkOutput("equal_duty", duty_a, 128);

    // Alternating valid/invalid samples with junk presented during DECIDE/UPDATE.
    va = '{20, 30, 40, 50};
    ia = '{9, 8, 7, 6};
    applyStimulus(va, ia, 1, 1, 1'b1, 1'b0);

    // Window aborted after two samples; the next window needs four fresh samples.
    abortWindow(2);
    va = '{5, 6, 7, 8};
    ia = '{4, 4, 4, 4};
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);

    // Randomized windows and aborts.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4, 0) == 0) begin
        abortWindow(int'($urandom_range(3, 0)));
      end else begin
        for (int k = 0; k < NS; k++) begin
          va[k] = int'($urandom_range(255, 0));
          ia[k] = int'($urandom_range(255, 0));
        end
        applyStimulus(va, ia, 0, 2, 1'($urandom), 1'b0);
      end
    end

    // Asynchronous reset mid-cycle, then full-scale samples.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkReset("async");
    @(negedge clk);
    rst = 1'b0;
    enterAccum();
    va = '{255, 255, 255, 255};
    ia = '{255, 255, 255, 255};
    applyStimulus(va, ia, 0, 1, 1'b0, 1'b0);
    checkOutput("full_scale_pavg", pavg_a, 65025);

    // Reset landing in UPDATE, then tracking resumes from the reset state.
    va = '{10, 10, 10, 10};
    ia = '{10, 10, 10, 10};
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    enterAccum();
    applyStimulus(va, ia, 0, 0, 1'b0, 1'b0);
    checkOutput("resume_duty", duty_a, 129);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mppt_po_tracker.md
MPPT_PO_TRACKER -- requirements
Module: mppt_po_tracker

Interface
REQ-001 Parameter W, default 8: width of the voltage and current sample inputs.
REQ-002 Parameter DUTY_W, default 8: width of the duty-cycle output.
REQ-003 Parameter AVG_LOG2, default 2: log2 of the number of samples averaged per window (4 by default).
REQ-004 Parameter STEP, default 1: duty increment or decrement applied per update.
REQ-005 Parameters DUTY_MIN = 16, DUTY_MAX = 240, DUTY_INIT = 128: duty saturation bounds and reset value, with DUTY_MIN <= DUTY_INIT <= DUTY_MAX.
REQ-006 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  tracking enable.
- v_in  in  W  unsigned voltage sample.
- i_in  in  W  unsigned current sample.
- s_valid  in  1  v_in/i_in valid this cycle.
- duty  out  DUTY_W  converter duty-cycle command.
- duty_upd  out  1  one-cycle pulse when duty is rewritten.
- p_avg  out  2W  latest window-average power.
- dir  out  1  perturbation direction; 1 = increase duty.
- state  out  2  FSM state encoding.

Function
REQ-007 The block SHALL compute power as the full-width unsigned product v_in*i_in (2W bits) and accumulate it in a 2W+AVG_LOG2-bit register with no overflow possible.
REQ-008 The FSM SHALL have states IDLE=0, ACCUM=1, DECIDE=2, UPDATE=3, driven on the state output.
REQ-009 IDLE: accumulator and sample count are held at 0; en=1 moves the FSM to ACCUM on the next edge.
REQ-010 ACCUM: each edge with s_valid=1 adds the product and increments the count; s_valid=0 cycles are ignored; the edge accepting sample number 2^AVG_LOG2 moves the FSM to DECIDE.
REQ-011 DECIDE (one cycle): p_avg <= accumulator >> AVG_LOG2 (truncating). On the first window since reset dir is unchanged; otherwise dir toggles if the new p_avg < p_prev and holds if it is >= p_prev. FSM -> UPDATE.
REQ-012 UPDATE (one cycle): duty <= duty+STEP if dir=1, else duty-STEP, saturated to [DUTY_MIN, DUTY_MAX].
REQ-013 In UPDATE: duty_upd=1 for exactly that edge's following cycle; p_prev <= p_avg; the first-window flag is cleared; accumulator and count are cleared; FSM -> ACCUM.
REQ-014 Saturation: if the updated duty equals DUTY_MAX, dir SHALL be forced to 0; if it equals DUTY_MIN, dir SHALL be forced to 1. The forced value overrides REQ-011 for the next window.
REQ-015 Latency: duty and duty_upd SHALL change on the 2nd rising edge after the edge accepting the window's final sample. Samples presented during DECIDE/UPDATE are discarded.
REQ-016 en=0 in any state SHALL move the FSM to IDLE on the next edge and clear accumulator and count; duty, dir, p_avg, p_prev and the first-window flag are held. No duty_upd is issued for a partial window.

Reset
REQ-017 While rst=1, asynchronously and independently of clk: duty=DUTY_INIT, dir=1, p_avg=0, p_prev=0, duty_upd=0, state=IDLE, accumulator=0, count=0, first-window flag set.
REQ-018 Reset asserted mid-window or in UPDATE SHALL abort the window immediately with no duty_upd pulse; operation resumes from IDLE on the first edge after rst falls.

Verification
REQ-019 Reset: rst=1 at any time -> duty=128, dir=1, p_avg=0, duty_upd=0, state=0 without a clock edge.
REQ-020 First window: en=1, four samples v=10,i=10 -> p_avg=100, dir=1, duty=129, single duty_upd pulse 2 edges after the 4th sample.
REQ-021 Tracking: next window v=10,i=12 -> p_avg=120, dir=1, duty=130. Following window v=10,i=11 -> p_avg=110, dir=0, duty=129. Following window v=10,i=11 (equal) -> dir stays 0, duty=128.
REQ-022 Saturation: DUTY_INIT=240 override, first window of any power -> duty=240, dir forced 0. Next window -> duty=239.
REQ-023 Gapped and aborted windows: s_valid toggled 1,0,1,0,... completes after 4 valid samples. en dropped after 2 samples -> state=0, no pulse, duty unchanged. Re-enable requires 4 fresh samples.
REQ-024 Width: four samples v=255,i=255 -> p_avg=65025, no wrap. Reset asserted during UPDATE -> duty=128, no duty_upd pulse.
